seg7_scan_driver: RTL and testbench

//  Parametrised multiplexed 7-segment display driver. Scans DIGITS common-select lines,

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_scan_driver_if.sv | 26 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 203 ++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// the hex segment table, idle pin levels and the scan FSM states.
// Segment bit order is {dp,g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  // Segment bus value for a dark digit
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Digit select value with no digit driven (active-low selects); sliced to DIGITS
  localparam logic [7:0] SEL_OFF = 8'hFF;

  // Hex glyphs 0-F, {g,f,e,d,c,b,a}; A,C,E,F upper case, b,d lower case
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f,
    7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c,
    7'h39, 7'h5e, 7'h79, 7'h71
  };

  // Scan phase within one digit slot
  typedef enum logic {
    S_DEAD = 1'b0,  // anti-ghosting gap: nothing selected, segments dark
    S_ON   = 1'b1   // current digit selected and lit
  } scan_state_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Update bus of the 7-segment scan driver: hex/dp/blank payload with an
// update strobe, plus pending/frame status back to the producer.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] data_i;     // nibble k = digit k, digit 0 rightmost
  logic [DIGITS-1:0]   dp_i;       // decimal point per digit, 1 = lit
  logic [DIGITS-1:0]   blank_i;    // force digit dark, 1 = blank
  logic                upd_i;      // capture payload into the shadow register
  logic                pending_o;  // shadow holds an uncommitted update
  logic                frame_o;    // one-cycle pulse at each frame commit

  // Producer side (status/counter logic)
  modport master (
    output data_i, dp_i, blank_i, upd_i,
    input  pending_o, frame_o
  );

  // Display driver side
  modport slave (
    input  data_i, dp_i, blank_i, upd_i,
    output pending_o, frame_o
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment glyph decoder ({g,f,e,d,c,b,a}).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_HEX[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver.
// A prescaler divides clk into digit slots of TICK_DIV cycles; each slot
// starts with DEAD_CYC blanked cycles (anti-ghosting) and then drives one
// active-low digit select with the decoded glyph. Updates land in a shadow
// register and are copied to the active register only when the scan wraps
// from the last digit back to digit 0, so a frame never shows mixed data.
// Optional feature: define LZ_BLANK_EN for leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000,
  parameter int DEAD_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus,
  output logic [7:0]          segment,
  output logic [DIGITS-1:0]   segsel
);

  localparam int PC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PC_W-1:0]  PC_LAST     = PC_W'(TICK_DIV - 1);
  localparam logic [PC_W-1:0]  PC_DEAD_END = PC_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DIGITS - 1);

  // With no dead time a new slot starts directly in S_ON
  localparam scan_state_e SLOT_START = (DEAD_CYC == 0) ? S_ON : S_DEAD;

  // Timing
  logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick;
  logic             commit;

  // Scan FSM
  scan_state_e      state_q, state_d;

  // Double buffer
  logic [4*DIGITS-1:0] shadow_data_q, active_data_q;
  logic [DIGITS-1:0]   shadow_dp_q,   active_dp_q;
  logic [DIGITS-1:0]   shadow_blank_q, active_blank_q;
  logic                pending_q;
  logic                frame_q;

  // Per-digit darkness and the currently scanned digit
  logic [DIGITS-1:0] dark_vec;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_dark;
  logic [6:0]        cur_glyph;

  // Registered pins
  logic [7:0]        segment_q, segment_d;
  logic [DIGITS-1:0] segsel_q, segsel_d;

  // Slot timing: prescaler wrap, digit advance and frame commit point
  always_comb begin
    pc_inc = pc_q + 1'b1;
    tick   = (pc_q == PC_LAST);
    commit = tick && (idx_q == IDX_LAST);
    pc_d   = tick ? '0 : pc_inc;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Prescaler and digit index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      idx_q <= '0;
    end else begin
      pc_q  <= pc_d;
      idx_q <= idx_d;
    end
  end

  // Darkness per digit: explicit blanking, plus leading-zero suppression when enabled
  always_comb begin
`ifdef LZ_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    dark_vec = active_blank_q;
`ifdef LZ_BLANK_EN
    // Walk from the MSD down; digit 0 always shows so a zero value reads "0"
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (active_data_q[k*4 +: 4] == 4'h0) && !active_dp_q[k]) begin
        dark_vec[k] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
`endif
  end

  // Select the nibble, decimal point and darkness of the digit being scanned
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib  = active_data_q[k*4 +: 4];
        cur_dp   = active_dp_q[k];
        cur_dark = dark_vec[k];
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble_i (cur_nib),
    .seg_o    (cur_glyph)
  );

  // Scan FSM next state and next pin values
  always_comb begin
    state_d   = state_q;
    segment_d = SEG_OFF;
    segsel_d  = SEL_OFF[DIGITS-1:0];

    if (tick) begin
      state_d = SLOT_START;
    end else if ((state_q == S_DEAD) && (pc_inc >= PC_DEAD_END)) begin
      state_d = S_ON;
    end

    if (state_q == S_ON) begin
      for (int k = 0; k < DIGITS; k++) begin
        segsel_d[k] = (idx_q != IDX_W'(k));
      end
      // A blanked digit keeps its select slot so the scan timing never shifts
      if (!cur_dark) begin
        segment_d = {cur_dp, cur_glyph};
      end
    end
  end

  // Scan FSM state and registered segment/select pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_DEAD;
      segment_q <= SEG_OFF;
      segsel_q  <= SEL_OFF[DIGITS-1:0];
    end else begin
      state_q   <= state_d;
      segment_q <= segment_d;
      segsel_q  <= segsel_d;
    end
  end

  // Shadow register: latest update strobe wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
    end else if (bus.upd_i) begin
      shadow_data_q  <= bus.data_i;
      shadow_dp_q    <= bus.dp_i;
      shadow_blank_q <= bus.blank_i;
    end
  end

  // Active register: loads the shadow only at the frame wrap, so no tearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_data_q  <= '0;
      active_dp_q    <= '0;
      active_blank_q <= '0;
    end else if (commit && pending_q) begin
      // An update on this same edge goes to the shadow; the old shadow is committed
      active_data_q  <= shadow_data_q;
      active_dp_q    <= shadow_dp_q;
      active_blank_q <= shadow_blank_q;
    end
  end

  // Pending flag and frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      frame_q <= commit;
      if (bus.upd_i) begin
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign bus.pending_o = pending_q;
  assign bus.frame_o   = frame_q;
  assign segment       = segment_q;
  assign segsel        = segsel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, TICK_DIV=8, DEAD_CYC=2).
// Expected frames are pushed to a queue when an update is committed by the
// bench's own model and popped when the DUT starts showing the next frame.
// Build with +define+LZ_BLANK_EN to exercise leading-zero suppression.
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 8;
  localparam int DEAD_CYC = 2;
  localparam int FRAME    = DIGITS * TICK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  segment;
  logic [3:0]  segsel;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .segment (segment),
    .segsel  (segsel)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] SEG_T [16] = '{
    8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
    8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71
  };

  logic [31:0] cur_exp;
  logic [31:0] shadow_exp;
  logic        exp_pending;
  logic [31:0] exp_q [$];
  logic [3:0]  cur_dp = 4'h0;
  logic [3:0]  cur_bl = 4'h0;

  // Expected segment bytes {d3,d2,d1,d0} for a payload
  function automatic logic [31:0] exp_frame(input logic [15:0] d, input logic [3:0] dp,
                                            input logic [3:0] bl);
    logic [31:0] r;
    logic [7:0]  s;
    logic [3:0]  n;
`ifdef LZ_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    r = '0;
    for (int k = 3; k >= 0; k--) begin
      n = d[k*4 +: 4];
      s = SEG_T[n];
      if (dp[k]) s[7] = 1'b1;
      if (bl[k]) s = 8'h00;
`ifdef LZ_BLANK_EN
      if (k != 0 && lead && n == 4'h0 && !dp[k]) s = 8'h00;
      else lead = 1'b0;
`endif
      r[k*8 +: 8] = s;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full frame of pin checks; updates driven at slot a0 (d0) and a1 (d1), -1 = none
  task automatic run_frame(input string tag, input int a0, input logic [15:0] d0,
                           input int a1, input logic [15:0] d1);
    for (int c = 0; c < FRAME; c++) begin
      int          p;
      int          ix;
      logic [3:0]  esel;
      logic [7:0]  eseg;
      logic        u;
      logic [15:0] ud;
      @(negedge clk);
      if (c == 0 && exp_q.size() != 0) cur_exp = exp_q.pop_front();
      p  = c % TICK_DIV;
      ix = c / TICK_DIV;
      if (p < DEAD_CYC) begin
        esel = 4'hF;
        eseg = 8'h00;
      end else begin
        esel = ~(4'b0001 << ix);
        eseg = cur_exp[ix*8 +: 8];
      end
      chk($sformatf("%s segsel slot%0d", tag, c), 32'(segsel), 32'(esel));
      chk($sformatf("%s segment slot%0d", tag, c), 32'(segment), 32'(eseg));
      chk($sformatf("%s frame_o slot%0d", tag, c), 32'(bus.frame_o), 32'(c == FRAME - 1));
      chk($sformatf("%s pending_o slot%0d", tag, c), 32'(bus.pending_o), 32'(exp_pending));
      u  = (c == a0) || (c == a1);
      ud = (c == a1) ? d1 : d0;
      bus.upd_i   = u;
      bus.data_i  = ud;
      bus.dp_i    = cur_dp;
      bus.blank_i = cur_bl;
      // Edge after slot FRAME-2 pins is the commit edge (last digit, last prescaler count)
      if (c == FRAME - 2 && exp_pending) begin
        exp_q.push_back(shadow_exp);
        exp_pending = 1'b0;
      end
      if (u) begin
        shadow_exp  = exp_frame(ud, cur_dp, cur_bl);
        exp_pending = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    cur_exp     = exp_frame(16'h0000, 4'h0, 4'h0);
    shadow_exp  = cur_exp;
    exp_pending = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bus.upd_i   = 1'b0;
    bus.data_i  = '0;
    bus.dp_i    = '0;
    bus.blank_i = '0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset segment", 32'(segment), 32'h00);
    chk("reset segsel", 32'(segsel), 32'hF);
    chk("reset pending_o", 32'(bus.pending_o), 32'h0);
    chk("reset frame_o", 32'(bus.frame_o), 32'h0);
    rst = 1'b0;
    model_reset();

    // Idle scan with all-zero data
    run_frame("idle0", -1, 16'h0, -1, 16'h0);
    run_frame("idle1", -1, 16'h0, -1, 16'h0);

    // Mid-frame update shows only after the next commit
    run_frame("upd12AF", 5, 16'h12AF, -1, 16'h0);
    run_frame("show12AF", -1, 16'h0, -1, 16'h0);

    // Two updates in one frame: latest wins
    run_frame("upd1111_2222", 4, 16'h1111, 12, 16'h2222);
    run_frame("show2222", -1, 16'h0, -1, 16'h0);

    // Update coincident with commit
    run_frame("upd4567_89AB", 6, 16'h4567, FRAME - 2, 16'h89AB);
    run_frame("show4567", -1, 16'h0, -1, 16'h0);
    run_frame("show89AB", -1, 16'h0, -1, 16'h0);

    // Blanking and decimal point
    cur_dp = 4'b0001;
    cur_bl = 4'b0100;
    run_frame("upd3210", 3, 16'h3210, -1, 16'h0);
    run_frame("show3210", -1, 16'h0, -1, 16'h0);

    // Zeros around a digit (suppressed only with LZ_BLANK_EN)
    cur_dp = 4'b0000;
    cur_bl = 4'b0000;
    run_frame("upd0050", 3, 16'h0050, -1, 16'h0);
    run_frame("show0050", -1, 16'h0, -1, 16'h0);

    // Asynchronous reset in the middle of a lit slot discards a pending update
    @(negedge clk);
    bus.data_i = 16'hFFFF;
    bus.upd_i  = 1'b1;
    @(negedge clk);
    bus.upd_i  = 1'b0;
    chk("pre-rst pending_o", 32'(bus.pending_o), 32'h1);
    repeat (11) @(negedge clk);
    chk("pre-rst segsel", 32'(segsel), 32'hD);
    #1 rst = 1'b1;
    #1;
    chk("async rst segsel", 32'(segsel), 32'hF);
    chk("async rst segment", 32'(segment), 32'h00);
    chk("async rst pending_o", 32'(bus.pending_o), 32'h0);
    chk("async rst frame_o", 32'(bus.frame_o), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_frame("post-rst", -1, 16'h0, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
